// File: rtl/alu16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu16_pkg
// Description : Shared widths, opcode constants and sequencer FSM states for
//               the alu16 command sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu16_pkg;

  // Default datapath widths of the alu16 operand/opcode interface
  localparam int ALU_DW  = 16;
  localparam int ALU_RW  = 32;
  localparam int ALU_OPW = 6;
  localparam int ALU_FW  = 7;

  // Opcodes whose meaning matters to users of the sequencer. The sequencer
  // itself forwards every opcode uninterpreted.
  localparam logic [ALU_OPW-1:0] OP_ADD       = 6'd1;
  localparam logic [ALU_OPW-1:0] OP_SUB       = 6'd2;
  localparam logic [ALU_OPW-1:0] OP_COUNTER   = 6'd23;
  localparam logic [ALU_OPW-1:0] OP_CLR_CARRY = 6'd24;
  localparam logic [ALU_OPW-1:0] OP_PUSH      = 6'd29;
  localparam logic [ALU_OPW-1:0] OP_POP       = 6'd30;
  localparam logic [ALU_OPW-1:0] OP_CLR_STACK = 6'd33;

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/alu16_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu16_cmd_sequencer_if
// Description : Command, ALU-drive and result channels of the alu16 command
//               sequencer. master = sequencer side, slave = environment side
//               (command producer, alu16 datapath, result consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu16_cmd_sequencer_if
  import alu16_pkg::*;
#(
  parameter int DW  = ALU_DW,
  parameter int RW  = ALU_RW,
  parameter int OPW = ALU_OPW,
  parameter int FW  = ALU_FW
) ();

  // Command channel
  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_op;
  logic [DW-1:0]  cmd_a;
  logic [DW-1:0]  cmd_b;

  // alu16 drive / sample
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic           alu_enable;
  logic [RW-1:0]  alu_c;
  logic [FW-1:0]  alu_flags;

  // Result channel
  logic           res_valid;
  logic           res_ready;
  logic [RW-1:0]  res_data;
  logic [FW-1:0]  res_flags;
  logic [OPW-1:0] res_op;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_c, alu_flags, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, alu_enable,
           res_valid, res_data, res_flags, res_op
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_c, alu_flags, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_enable,
           res_valid, res_data, res_flags, res_op
  );

endinterface
`default_nettype wire

// File: rtl/alu16_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu16_cmd_fifo
// Description : DEPTH x W command FIFO with registered count and a registered
//               write-ready that never depends on a same-cycle read.
// Revision    : 1.0 - initial release
// ============================================================================
module alu16_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  output logic         ready_o,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o
);

  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          ready_q;
  logic          w_push;
  logic          w_pop;
  logic          w_full_d;

  // ready_q is low while full and for the reset cycle, so it gates the push
  assign w_push   = wr_en_i & ready_q;
  assign w_pop    = rd_en_i & (count_q != '0);
  assign w_full_d = (count_d == C_FULL);

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and write-ready; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= ~w_full_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign ready_o   = ready_q;
  assign empty_o   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu16_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu16_cmd_sequencer
// Description : Queues {op,a,b} commands, drives alu16 one command at a time
//               with a SETTLE-cycle enable pulse, captures c/flags on the last
//               settle cycle and returns results in order over valid/ready.
//               Optional ALU_SEQ_STATS_EN adds saturating stat_issued and
//               stat_stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu16_cmd_sequencer
  import alu16_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int DW     = ALU_DW,
  parameter int RW     = ALU_RW,
  parameter int OPW    = ALU_OPW,
  parameter int FW     = ALU_FW
) (
  input  logic                  clk,
  input  logic                  rst,
  alu16_cmd_sequencer_if.master bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]           stat_issued,
  output logic [15:0]           stat_stall
`endif
);

  localparam int            FIFO_W   = OPW + 2*DW;
  localparam int            CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE);
  localparam logic [CW-1:0] C_LAST   = CW'(1);

  seq_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic           alu_en_q, alu_en_d;
  logic           res_valid_q, res_valid_d;
  logic [RW-1:0]  res_data_q, res_data_d;
  logic [FW-1:0]  res_flags_q, res_flags_d;
  logic [OPW-1:0] res_op_q, res_op_d;

  logic              w_fifo_pop;
  logic              w_fifo_empty;
  logic [FIFO_W-1:0] w_fifo_rd_data;

  alu16_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bus.cmd_valid),
    .wr_data_i ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .ready_o   (bus.cmd_ready),
    .rd_en_i   (w_fifo_pop),
    .rd_data_o (w_fifo_rd_data),
    .empty_o   (w_fifo_empty)
  );

  // Next-state logic: issue from FIFO, count out the settle window, hold result
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_en_d    = alu_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_op_d    = res_op_q;
    w_fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop                     = 1'b1;
          {alu_op_d, alu_a_d, alu_b_d}   = w_fifo_rd_data;
          alu_en_d                       = 1'b1;
          cnt_d                          = C_SETTLE;
          state_d                        = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // c is only valid while enable is high, so capture on the last cycle
        if (cnt_q == C_LAST) begin
          res_data_d  = bus.alu_c;
          res_flags_d = bus.alu_flags;
          res_op_d    = alu_op_q;
          res_valid_d = 1'b1;
          alu_en_d    = 1'b0;
          cnt_d       = '0;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        alu_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_en_q    <= alu_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_op_q    <= res_op_d;
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_enable = alu_en_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_flags  = res_flags_q;
  assign bus.res_op     = res_op_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_issued_q;
  logic [15:0] stat_stall_q;

  // Saturating issue and back-pressure counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_SETTLE && stat_issued_q != 16'hFFFF)
        stat_issued_q <= stat_issued_q + 16'd1;
      if (res_valid_q && !bus.res_ready && stat_stall_q != 16'hFFFF)
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule
`default_nettype wire
